// File: rtl/rvm_mem_arbiter.sv
`timescale 1ns/1ps
// rvm_mem_arbiter: round-robin arbiter sharing one SRAM bus between the
// instruction-fetch port (0) and the load/store port (1), with a stall watchdog.
module rvm_mem_arbiter #(
  parameter logic [15:0] STALL_LIMIT = 16'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_b_en,
  input  logic        p0_w_en,
  output logic [31:0] p0_rdata,
  output logic        p0_ack,
  output logic        p0_error,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_b_en,
  input  logic        p1_w_en,
  output logic [31:0] p1_rdata,
  output logic        p1_ack,
  output logic        p1_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_b_en,
  output logic        mem_w_en,
  output logic        mem_c_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall,
  input  logic        mem_error
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        own, own_nxt;
  logic        pri, pri_nxt;
  logic [15:0] stall_cnt, stall_cnt_nxt;

  logic [31:0] mem_addr_nxt, mem_wdata_nxt;
  logic [3:0]  mem_b_en_nxt;
  logic        mem_w_en_nxt, mem_c_en_nxt;
  logic [31:0] p0_rdata_nxt, p1_rdata_nxt;
  logic        p0_ack_nxt, p1_ack_nxt;
  logic        p0_error_nxt, p1_error_nxt;

  logic        elig0, elig1, winner, done;
  logic [31:0] done_rdata;
  logic        done_error;

  // True on the stalled cycle that reaches the limit; a limit of 0 never fires.
  function automatic logic watchdog_fire(input logic [15:0] cnt);
    return (STALL_LIMIT != 16'd0) &&
           (({1'b0, cnt} + 17'd1) == {1'b0, STALL_LIMIT});
  endfunction

  // A port is masked in its own ack cycle so a still-held request is not regranted.
  assign elig0  = p0_req & ~p0_ack;
  assign elig1  = p1_req & ~p1_ack;
  assign winner = (elig0 & elig1) ? pri : elig1;

  assign done       = (state == BUSY) & (~mem_stall | watchdog_fire(stall_cnt));
  assign done_rdata = mem_stall ? 32'h0 : mem_rdata;
  assign done_error = mem_stall | mem_error;

  always_comb begin
    state_nxt     = state;
    own_nxt       = own;
    pri_nxt       = pri;
    stall_cnt_nxt = stall_cnt;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_b_en_nxt  = mem_b_en;
    mem_w_en_nxt  = mem_w_en;
    mem_c_en_nxt  = mem_c_en;
    p0_rdata_nxt  = p0_rdata;
    p1_rdata_nxt  = p1_rdata;
    p0_error_nxt  = p0_error;
    p1_error_nxt  = p1_error;
    p0_ack_nxt    = 1'b0;
    p1_ack_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          state_nxt     = BUSY;
          own_nxt       = winner;
          stall_cnt_nxt = 16'd0;
          mem_c_en_nxt  = 1'b1;
          mem_addr_nxt  = winner ? p1_addr  : p0_addr;
          mem_wdata_nxt = winner ? p1_wdata : p0_wdata;
          mem_b_en_nxt  = winner ? p1_b_en  : p0_b_en;
          mem_w_en_nxt  = winner ? p1_w_en  : p0_w_en;
        end
      end
      BUSY: begin
        if (done) begin
          state_nxt     = IDLE;
          pri_nxt       = ~own;
          mem_c_en_nxt  = 1'b0;
          mem_addr_nxt  = 32'h0;
          mem_wdata_nxt = 32'h0;
          mem_b_en_nxt  = 4'h0;
          mem_w_en_nxt  = 1'b0;
          if (own) begin
            p1_ack_nxt   = 1'b1;
            p1_rdata_nxt = done_rdata;
            p1_error_nxt = done_error;
          end else begin
            p0_ack_nxt   = 1'b1;
            p0_rdata_nxt = done_rdata;
            p0_error_nxt = done_error;
          end
        end else if (stall_cnt != 16'hFFFF) begin
          // Saturates only when the watchdog is disabled.
          stall_cnt_nxt = stall_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      own       <= 1'b0;
      pri       <= 1'b0;
      stall_cnt <= 16'd0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_b_en  <= 4'h0;
      mem_w_en  <= 1'b0;
      mem_c_en  <= 1'b0;
      p0_rdata  <= 32'h0;
      p1_rdata  <= 32'h0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_error  <= 1'b0;
      p1_error  <= 1'b0;
    end else begin
      state     <= state_nxt;
      own       <= own_nxt;
      pri       <= pri_nxt;
      stall_cnt <= stall_cnt_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_b_en  <= mem_b_en_nxt;
      mem_w_en  <= mem_w_en_nxt;
      mem_c_en  <= mem_c_en_nxt;
      p0_rdata  <= p0_rdata_nxt;
      p1_rdata  <= p1_rdata_nxt;
      p0_ack    <= p0_ack_nxt;
      p1_ack    <= p1_ack_nxt;
      p0_error  <= p0_error_nxt;
      p1_error  <= p1_error_nxt;
    end
  end

endmodule

// File: doc/rvm_mem_arbiter.md
# rvm_mem_arbiter

Two-port, round-robin arbiter that shares the single `sram` memory bus between the core's instruction-fetch port (port 0) and load/store port (port 1). It holds one transaction at a time, latches the winning request onto the memory bus and waits out `mem_stall`. It returns read data, an acknowledge and an error flag to the owning requester. A stall watchdog aborts transactions that hang.

## Interface
- `STALL_LIMIT`, 16'd255: number of consecutive stalled busy cycles before a transaction is aborted. 0 disables the watchdog. Maximum 65535.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p0_req`  in  1  port 0 request; held with its payload until `p0_ack`.
- `p0_addr`  in  32  port 0 address.
- `p0_wdata`  in  32  port 0 write data.
- `p0_b_en`  in  4  port 0 byte enables.
- `p0_w_en`  in  1  port 0 write (1) / read (0).
- `p0_rdata`  out  32  port 0 read data; valid while `p0_ack`=1, then held.
- `p0_ack`  out  1  one-cycle completion pulse.
- `p0_error`  out  1  error qualifier; valid with `p0_ack`.
- `p1_*`: same set of signals as port 0, for port 1.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_b_en`  out  4  memory byte enables.
- `mem_w_en`  out  1  memory write enable.
- `mem_c_en`  out  1  memory transaction active.
- `mem_rdata`  in  32  memory read data.
- `mem_stall`  in  1  memory not ready this cycle.
- `mem_error`  in  1  memory error; sampled on completion.

## Operation
- **States.** IDLE, BUSY. One state register plus an owner bit `own`.
- **Reset values.**
  - All outputs 0, including `mem_*`, `*_ack`, `*_error` and `*_rdata`.
  - State is IDLE, stall counter is 0, and the priority pointer `pri` = port 0.
- **IDLE.**
  - Eligible request: `pN_req`=1 and `pN_ack`=0 in the current cycle. A port's request is masked in its own ack cycle.
  - If no request is eligible, stay in IDLE.
  - If exactly one port is eligible, that port wins.
  - If both ports are eligible, port `pri` wins.
  - On a win, register the winner's addr, wdata, b_en and w_en onto `mem_*`. Set `mem_c_en`=1, set `own`=winner, clear the counter and go to BUSY.
- **BUSY.** `mem_*` outputs are held constant. Requester inputs are ignored.
  - **Completion.** `mem_stall`=0: capture `mem_rdata` into `p[own]_rdata` and `mem_error` into `p[own]_error`. Pulse `p[own]_ack`. Set `pri` = the port that was not `own`. Drive `mem_*` to 0 and go to IDLE.
  - **Stall.** `mem_stall`=1 and counter+1 < `STALL_LIMIT` (or `STALL_LIMIT`=0): increment the counter and stay in BUSY.
  - **Abort.** `mem_stall`=1 and counter+1 == `STALL_LIMIT`: handle as a completion, with `p[own]_error`=1 and `p[own]_rdata`=0.
- **Non-owner outputs.** The non-owner port's ack, error and rdata are unchanged.
- **Writes.** Completion is identical to a read; rdata is still captured from `mem_rdata`.
- **Reset in BUSY.** Reset mid-transaction drops the transaction silently: no ack, `mem_c_en`=0 from the next cycle, `pri` = port 0.

## Timing
- A request sampled in IDLE cycle 0 puts `mem_c_en`=1 with its payload on the bus in cycle 1.
- With zero stalls, the ack is high in cycle 2 and the bus is idle in cycle 2.
- Each stalled BUSY cycle adds one cycle of latency.
- The earliest next grant is sampled in the ack cycle, with the bus driven one cycle later. Back-to-back throughput is therefore one transaction per 2 cycles.
- Port N must keep `pN_req` and its payload stable from assertion until the cycle `pN_ack` is seen. It may drop or change them in the cycle after.
- Only one of `p0_ack` and `p1_ack` is ever high in a cycle.
- The stall counter is 16 bits and cannot wrap, since it is bounded by `STALL_LIMIT`.

## Test plan
- **Single read.** `p0_req`, addr 0x100, read, `mem_stall`=0, `mem_rdata`=0xDEADBEEF. Required: cycle 1 has `mem_c_en`=1 and `mem_addr`=0x100; cycle 2 has `p0_ack`=1, `p0_rdata`=0xDEADBEEF, `p0_error`=0.
- **Contention.** Both ports request continuously from reset, p0 addr 0x10, p1 addr 0x20. Required: bus addresses in cycles 1, 3, 5, 7 are 0x10, 0x20, 0x10, 0x20; acks alternate p0, p1.
- **Stalls.** `mem_stall`=1 for BUSY cycles 1–3, then 0. Required: ack in cycle 5; `mem_addr` is constant over cycles 1–4.
- **Write error.** p1 write with `mem_w_en`=1, `mem_b_en`=4'b0011, wdata 0xCAFE0000, and `mem_error`=1 at completion. Required: `p1_ack`=1 and `p1_error`=1; p0 outputs unchanged.
- **Watchdog.** `STALL_LIMIT`=4, `mem_stall` held at 1. Required: ack with error=1 and rdata=0 in cycle 5; `mem_c_en`=0 in cycle 5.
- **Reset in BUSY.** `reset` asserted in BUSY cycle 2 of a stalled p1 transaction. Required: no ack; all outputs 0 in the next cycle; a subsequent simultaneous request is granted to p0 first.
